// File: rtl/adc_reg_readback_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_rb_pkg                                                           |
// | Shared constants, state encoding and frame-word helper for the ADC   |
// | register readback engine.                                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package adc_rb_pkg;

    localparam int FRAME_BITS = 16;
    localparam int RD_BITS    = 8;

    localparam logic [7:0] RO_ON  = 8'h01;
    localparam logic [7:0] RO_OFF = 8'h00;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        GAPW  = 3'd3,
        FIN   = 3'd4
    } state_t;

    // Word sent in each frame of a read: enable readout, read, disable readout.
    function automatic logic [FRAME_BITS-1:0] frame_word(
        input logic [1:0] idx,
        input logic [7:0] ro_reg,
        input logic [7:0] rd_addr
    );
        logic [FRAME_BITS-1:0] w;
        case (idx)
            2'd0:    w = {ro_reg, RO_ON};
            2'd1:    w = {rd_addr, 8'h00};
            default: w = {ro_reg, RO_OFF};
        endcase
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_reg_readback_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_reg_readback_if                                                  |
// | Request/result handshake plus ADC serial pins of the readback engine.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface adc_reg_readback_if;
    import adc_rb_pkg::*;

    logic                 start;
    logic [7:0]           addr;
    logic                 busy;
    logic                 done;
    logic [RD_BITS-1:0]   rdata;
    logic                 sen;
    logic                 sclk;
    logic                 sdata;
    logic                 sdout;

    modport master (
        output start, addr, sdout,
        input  busy, done, rdata, sen, sclk, sdata
    );

    modport slave (
        input  start, addr, sdout,
        output busy, done, rdata, sen, sclk, sdata
    );

endinterface
`default_nettype wire

// File: rtl/adc_spi_frame.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_spi_frame                                                        |
// | Single 16-bit SEN/SCLK/SDATA frame with capture of the last 8 SDOUT  |
// | bits. ADC_RB_SYNC_EN adds a 2-flop SDOUT synchronizer.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module adc_spi_frame
    import adc_rb_pkg::*;
#(
    parameter int CLKDIV = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  i_go,
    input  wire logic                  i_cap_en,
    input  wire logic [FRAME_BITS-1:0] i_word,
    input  wire logic                  i_sdout,
    output logic                       o_sen,
    output logic                       o_sclk,
    output logic                       o_sdata,
    output logic [RD_BITS-1:0]         o_tail,
    output logic                       o_shifting,
    output logic                       o_frame_done
);

    localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

    generate
        if (CLKDIV < 2 || CLKDIV > 255) begin : g_clkdiv_range
            $error("adc_spi_frame: CLKDIV must be in 2..255");
        end
    endgenerate

    logic w_sample;

`ifdef ADC_RB_SYNC_EN
    localparam logic [7:0] CAP_DIV = 8'd2;

    generate
        if (CLKDIV < 3) begin : g_sync_clkdiv_chk
            $error("adc_spi_frame: ADC_RB_SYNC_EN requires CLKDIV >= 3");
        end
    endgenerate

    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], i_sdout};
    end
    assign w_sample = sync_q[1];
`else
    localparam logic [7:0] CAP_DIV = 8'd0;
    assign w_sample = i_sdout;
`endif

    state_t                 st_q, st_d;
    logic [7:0]             div_q, div_d;
    logic [4:0]             half_q, half_d;
    logic [FRAME_BITS-1:0]  word_q, word_d;
    logic [RD_BITS-1:0]     tail_q, tail_d;
    logic                   sen_q, sen_d;
    logic                   sclk_q, sclk_d;
    logic                   sdata_q, sdata_d;
    logic                   w_div_end;
    logic                   w_capture;

    assign w_div_end = (div_q == DIV_LAST);
    // half_q[4] marks periods 8..15, i.e. the data byte of the frame.
    assign w_capture = i_cap_en && (st_q == SHIFT) && sclk_q && half_q[4] && (div_q == CAP_DIV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= IDLE;
            div_q   <= 8'd0;
            half_q  <= 5'd0;
            word_q  <= '0;
            tail_q  <= '0;
            sen_q   <= 1'b1;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            div_q   <= div_d;
            half_q  <= half_d;
            word_q  <= word_d;
            tail_q  <= tail_d;
            sen_q   <= sen_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
        end
    end

    always_comb begin
        st_d         = st_q;
        div_d        = div_q;
        half_d       = half_q;
        word_d       = word_q;
        tail_d       = tail_q;
        sen_d        = sen_q;
        sclk_d       = sclk_q;
        sdata_d      = sdata_q;
        o_frame_done = 1'b0;

        if (w_capture) tail_d = {tail_q[RD_BITS-2:0], w_sample};

        case (st_q)
            IDLE: begin
                if (i_go) begin
                    st_d    = SETUP;
                    div_d   = 8'd0;
                    sen_d   = 1'b0;
                    sclk_d  = 1'b0;
                    sdata_d = i_word[FRAME_BITS-1];
                    word_d  = {i_word[FRAME_BITS-2:0], 1'b0};
                end
            end
            SETUP: begin
                if (w_div_end) begin
                    st_d   = SHIFT;
                    div_d  = 8'd0;
                    half_d = 5'd0;
                    sclk_d = 1'b1;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            SHIFT: begin
                if (!w_div_end) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d  = 8'd0;
                    half_d = half_q + 5'd1;
                    sclk_d = ~sclk_q;
                    if (sclk_q) begin
                        sdata_d = word_q[FRAME_BITS-1];
                        word_d  = {word_q[FRAME_BITS-2:0], 1'b0};
                    end
                    if (half_q == 5'd31) begin
                        st_d         = IDLE;
                        sen_d        = 1'b1;
                        sclk_d       = 1'b0;
                        sdata_d      = 1'b0;
                        o_frame_done = 1'b1;
                    end
                end
            end
            default: st_d = IDLE;
        endcase
    end

    assign o_sen      = sen_q;
    assign o_sclk     = sclk_q;
    assign o_sdata    = sdata_q;
    assign o_tail     = tail_q;
    assign o_shifting = (st_q == SHIFT);

endmodule
`default_nettype wire

// File: rtl/adc_reg_readback.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_reg_readback                                                     |
// | Three-frame ADC register read (enable readout, read, disable) that   |
// | returns the 8-bit value. Optional macro: ADC_RB_SYNC_EN.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module adc_reg_readback
    import adc_rb_pkg::*;
#(
    parameter int         CLKDIV = 4,
    parameter int         GAP    = 8,
    parameter logic [7:0] RO_REG = 8'h00
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    adc_reg_readback_if.slave  bus
);

    localparam logic [15:0] GAP_LAST     = 16'(GAP - 1);
    localparam logic [15:0] GAP_FIN_LAST = 16'(GAP - 2);

    generate
        if (GAP < 1) begin : g_gap_chk
            $error("adc_reg_readback: GAP must be at least 1");
        end
    endgenerate

    state_t                 state_q, state_d;
    logic [1:0]             fcnt_q, fcnt_d;
    logic [15:0]            gcnt_q, gcnt_d;
    logic [7:0]             addr_q, addr_d;
    logic [RD_BITS-1:0]     rdata_q, rdata_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   w_go;
    logic [FRAME_BITS-1:0]  w_word;
    logic [RD_BITS-1:0]     w_tail;
    logic                   w_shifting;
    logic                   w_frame_done;
    logic                   w_sen, w_sclk, w_sdata;

    // Word is selected from the next frame index so it is valid on the go cycle.
    assign w_word = frame_word(fcnt_d, RO_REG, addr_q);

    adc_spi_frame #(
        .CLKDIV (CLKDIV)
    ) u_frame (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_go         (w_go),
        .i_cap_en     (fcnt_q == 2'd1),
        .i_word       (w_word),
        .i_sdout      (bus.sdout),
        .o_sen        (w_sen),
        .o_sclk       (w_sclk),
        .o_sdata      (w_sdata),
        .o_tail       (w_tail),
        .o_shifting   (w_shifting),
        .o_frame_done (w_frame_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fcnt_q  <= 2'd0;
            gcnt_q  <= 16'd0;
            addr_q  <= 8'h00;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            gcnt_q  <= gcnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        gcnt_d  = gcnt_q;
        addr_d  = addr_q;
        w_go    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    addr_d  = bus.addr;
                    fcnt_d  = 2'd0;
                    w_go    = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (w_shifting) state_d = SHIFT;
            end
            SHIFT: begin
                if (w_frame_done) begin
                    gcnt_d = 16'd0;
                    // FIN doubles as the last cycle of the trailing gap.
                    if (fcnt_q == 2'd2 && GAP == 1) state_d = FIN;
                    else                            state_d = GAPW;
                end
            end
            GAPW: begin
                gcnt_d = gcnt_q + 16'd1;
                if (fcnt_q == 2'd2) begin
                    if (gcnt_q == GAP_FIN_LAST) state_d = FIN;
                end else if (gcnt_q == GAP_LAST) begin
                    fcnt_d  = fcnt_q + 2'd1;
                    w_go    = 1'b1;
                    state_d = SETUP;
                end
            end
            FIN: begin
                fcnt_d  = 2'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (fcnt_q == 2'd3) begin
            state_d = IDLE;
            fcnt_d  = 2'd0;
            w_go    = 1'b0;
        end

        busy_d  = (state_d == SETUP) || (state_d == SHIFT) || (state_d == GAPW);
        done_d  = (state_d == FIN);
        rdata_d = (state_d == FIN) ? w_tail : rdata_q;
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
    assign bus.sen   = w_sen;
    assign bus.sclk  = w_sclk;
    assign bus.sdata = w_sdata;

endmodule
`default_nettype wire

// File: tb/tb_adc_reg_readback.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_adc_reg_readback                                                  |
// | Bench for adc_reg_readback: two instances, behavioural ADC model.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_adc_reg_readback;

    localparam int         C_CD0 = 4;
    localparam int         C_GP0 = 8;
`ifdef ADC_RB_SYNC_EN
    localparam int         C_CD1 = 3;
`else
    localparam int         C_CD1 = 2;
`endif
    localparam int         C_GP1 = 1;
    localparam logic [7:0] C_RO  = 8'h00;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    adc_reg_readback_if bus0 ();
    adc_reg_readback_if bus1 ();

    adc_reg_readback #(.CLKDIV(C_CD0), .GAP(C_GP0), .RO_REG(C_RO)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    adc_reg_readback #(.CLKDIV(C_CD1), .GAP(C_GP1), .RO_REG(C_RO)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    logic [1:0] start_r = 2'b00;
    logic [1:0] sdout_r = 2'b00;
    logic [7:0] addr_r  [2];
    logic [7:0] ret_val [2];
    logic [1:0] w_busy, w_done, w_sen, w_sclk, w_sdata;
    logic [7:0] w_rdata [2];

    assign bus0.start = start_r[0];  assign bus1.start = start_r[1];
    assign bus0.addr  = addr_r[0];   assign bus1.addr  = addr_r[1];
    assign bus0.sdout = sdout_r[0];  assign bus1.sdout = sdout_r[1];
    assign w_busy  = {bus1.busy,  bus0.busy};
    assign w_done  = {bus1.done,  bus0.done};
    assign w_sen   = {bus1.sen,   bus0.sen};
    assign w_sclk  = {bus1.sclk,  bus0.sclk};
    assign w_sdata = {bus1.sdata, bus0.sdata};
    assign w_rdata[0] = bus0.rdata;
    assign w_rdata[1] = bus1.rdata;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int cd_of(input int k);
        return (k == 0) ? C_CD0 : C_CD1;
    endfunction

    function automatic int gap_of(input int k);
        return (k == 0) ? C_GP0 : C_GP1;
    endfunction

    // ADC model: decodes frames, tracks READOUT, drives SDOUT after falls.
    logic [15:0] fq [$];
    int          gq [$];
    int          per_bad = 0;
    int          frames_seen = 0;
    bit          prev_sen  [2] = '{1'b1, 1'b1};
    bit          prev_sclk [2] = '{1'b0, 1'b0};
    bit          readout   [2] = '{1'b0, 1'b0};
    int          rises [2], falls [2], last_rise [2], gapcnt [2];
    logic [15:0] sh [2];

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (prev_sen[k] && !w_sen[k]) begin
                if (frames_seen > 0) gq.push_back(gapcnt[k]);
                rises[k] = 0;
                falls[k] = 0;
                sh[k]    = 16'h0;
            end
            if (!w_sen[k]) begin
                if (!prev_sclk[k] && w_sclk[k]) begin
                    if (rises[k] > 0 && (cyc - last_rise[k]) != 2 * cd_of(k)) per_bad++;
                    last_rise[k] = cyc;
                    sh[k] = {sh[k][14:0], w_sdata[k]};
                    rises[k]++;
                end
                if (prev_sclk[k] && !w_sclk[k]) begin
                    falls[k]++;
                    if (falls[k] >= 8 && falls[k] <= 15 && readout[k])
                        sdout_r[k] = ret_val[k][15 - falls[k]];
                    else
                        sdout_r[k] = 1'b0;
                end
            end
            if (!prev_sen[k] && w_sen[k]) begin
                if (rises[k] == 16) begin
                    fq.push_back(sh[k]);
                    frames_seen++;
                    if (sh[k][15:8] == C_RO) readout[k] = sh[k][0];
                end
                gapcnt[k] = 0;
            end
            if (w_sen[k]) gapcnt[k]++;
            prev_sen[k]  = w_sen[k];
            prev_sclk[k] = w_sclk[k];
        end
    end

    task automatic check_reset_vals(input int k, input string pfx);
        check({pfx, "_sen"},   32'(w_sen[k]),   32'd1);
        check({pfx, "_sclk"},  32'(w_sclk[k]),  32'd0);
        check({pfx, "_sdata"}, 32'(w_sdata[k]), 32'd0);
        check({pfx, "_busy"},  32'(w_busy[k]),  32'd0);
        check({pfx, "_done"},  32'(w_done[k]),  32'd0);
        check({pfx, "_rdata"}, 32'(w_rdata[k]), 32'h00);
    endtask

    task automatic do_read(input int k, input logic [7:0] a, input logic [7:0] v,
                           input int extra_at, input int rst_at, input int tail);
        int          c0, lat, bsy, ndone, exp_lat, lim;
        logic [15:0] expw [3];
        exp_lat = 3 * (33 * cd_of(k) + gap_of(k));
        lim     = exp_lat + 40;
        expw[0] = {C_RO, 8'h01};
        expw[1] = {a, 8'h00};
        expw[2] = {C_RO, 8'h00};
        ret_val[k] = v;
        @(negedge clk);
        fq.delete();
        gq.delete();
        per_bad     = 0;
        frames_seen = 0;
        start_r[k]  = 1'b1;
        addr_r[k]   = a;
        c0 = cyc;
        @(negedge clk);
        start_r[k] = 1'b0;
        addr_r[k]  = 8'($urandom);
        lat = -1; bsy = 0; ndone = 0;
        for (int i = 0; i < lim; i++) begin
            if (w_busy[k]) bsy++;
            if (w_done[k]) begin
                ndone++;
                if (lat < 0) lat = cyc - c0;
            end
            if (lat >= 0 && (cyc - c0) >= lat + tail) break;
            start_r[k] = ((cyc - c0) == extra_at);
            if ((cyc - c0) == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_vals(k, "midrst");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
        end
        start_r[k] = 1'b0;
        check("latency",     32'(lat),       32'(exp_lat));
        check("busy_cycles", 32'(bsy),       32'(exp_lat - 1));
        check("done_count",  32'(ndone),     32'd1);
        check("rdata",       32'(w_rdata[k]), 32'(v));
        check("frame_count", 32'(fq.size()), 32'd3);
        for (int i = 0; i < fq.size() && i < 3; i++) check("frame_word", 32'(fq[i]), 32'(expw[i]));
        check("gap_count",   32'(gq.size()), 32'd2);
        for (int i = 0; i < gq.size(); i++) check("sen_gap", 32'(gq[i]), 32'(gap_of(k)));
        check("sclk_period_errs", 32'(per_bad), 32'd0);
    endtask

    initial begin
        addr_r[0] = 8'h00; addr_r[1] = 8'h00;
        ret_val[0] = 8'h00; ret_val[1] = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals(0, "rst0");
        check_reset_vals(1, "rst1");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_read(0, 8'h3D, 8'hA5, -1, 200, 0);
        repeat (2) @(negedge clk);
        check_reset_vals(0, "postrst");

        do_read(0, 8'h3D, 8'hA5, -1, -1, 0);
        do_read(0, 8'h3D, 8'hA5, 100, -1, 4);
        do_read(0, 8'h3D, 8'hA5, -1, -1, 0);
        do_read(0, 8'h3D, 8'h5A, 3 * (33 * C_CD0 + C_GP0), -1, 4);
        check("fin_start_ignored", 32'(w_busy[0]), 32'd0);
        do_read(0, 8'h12, 8'h00, -1, -1, 0);
        do_read(0, 8'h7E, 8'hFF, -1, -1, 0);

        do_read(1, 8'h3D, 8'hA5, -1, -1, 0);
        do_read(1, 8'h01, 8'h00, -1, -1, 0);
        do_read(1, 8'hC4, 8'hFF, -1, -1, 0);

        for (int i = 0; i < 6; i++)
            do_read(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), -1, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
